// File: rtl/spi_pkg.sv
// Shared types and helpers for the SPI register-file target.
// Frame layout: 8-bit command word, then a burst of data words.
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CMD,
    DATA
  } spi_state_t;

  localparam int CMD_W  = 8;
  localparam int RW_BIT = 7;
  localparam int ADDR_W = 7;

  function automatic logic [ADDR_W-1:0] addr_wrap(
    input logic [ADDR_W-1:0] addr,
    input int                num_regs
  );
    if (int'(addr) == num_regs - 1)
      return '0;
    return addr + ADDR_W'(1);
  endfunction

endpackage

// File: rtl/spi_edge_sync.sv
// Two-flop synchroniser plus one history flop for edge detection.
// rise/fall are single-cycle pulses derived from the synchronised level.
module spi_edge_sync (
  input  logic iclk,
  input  logic rst,
  input  logic din,
  output logic sync,
  output logic rise,
  output logic fall
);

  logic s1;
  logic s2;
  logic s3;

  always_ff @(posedge iclk) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= din;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign sync = s2;
  assign rise = s2 & ~s3;
  assign fall = ~s2 & s3;

endmodule

// File: rtl/spi_regfile_target.sv
// SPI mode-0 target with an oversampled serial port and a burst register file.
// Low addresses are writable, the rest mirror rd_regs; frames end on sclk idle.
module spi_regfile_target
  import spi_pkg::*;
#(
  parameter int              DATA_W      = 8,
  parameter int              NUM_REGS    = 60,
  parameter int              NUM_WR      = 4,
  parameter int              TIMEOUT_CYC = 64,
  parameter logic [DATA_W-1:0] WR_RST_VAL = '0
) (
  input  logic                              iclk,
  input  logic                              rst,
  input  logic                              sclk,
  input  logic                              serial_in,
  output logic                              serial_out,
  input  logic [(NUM_REGS-NUM_WR)*DATA_W-1:0] rd_regs,
  output logic [NUM_WR*DATA_W-1:0]          wr_regs,
  output logic [NUM_WR-1:0]                 wr_strobe,
  output logic                              frame_active,
  output logic                              addr_err
);

  localparam int RX_W  = (DATA_W > CMD_W) ? DATA_W : CMD_W;
  localparam int CNT_W = $clog2(RX_W) + 1;
  localparam int TO_W  = $clog2(TIMEOUT_CYC + 1);
  localparam int MAP_N = 2 ** ADDR_W;

  localparam logic [CNT_W-1:0] CMD_LAST  = CNT_W'(CMD_W - 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);
  localparam logic [TO_W-1:0]  TO_MAX    = TO_W'(TIMEOUT_CYC);

  logic sclk_rise;
  logic sclk_fall;
  logic sclk_lvl;

  spi_edge_sync u_sclk_sync (
    .iclk (iclk),
    .rst  (rst),
    .din  (sclk),
    .sync (sclk_lvl),
    .rise (sclk_rise),
    .fall (sclk_fall)
  );

  logic din_s1;
  logic din_s;

  always_ff @(posedge iclk) begin
    if (rst) begin
      din_s1 <= 1'b0;
      din_s  <= 1'b0;
    end else begin
      din_s1 <= serial_in;
      din_s  <= din_s1;
    end
  end

  spi_state_t          state;
  logic [CNT_W-1:0]    bit_cnt;
  logic [TO_W-1:0]     to_cnt;
  logic [RX_W-1:0]     rx;
  logic [DATA_W-1:0]   tx;
  logic [ADDR_W-1:0]   addr;
  logic                rw;
  logic                commit_en;
  logic [ADDR_W-1:0]   commit_addr;
  logic [DATA_W-1:0]   commit_data;
  logic [DATA_W-1:0]   wr_q [NUM_WR];
  logic [DATA_W-1:0]   map  [MAP_N];

  logic [RX_W-1:0]     rx_n;
  logic [ADDR_W-1:0]   cmd_addr;
  logic [ADDR_W-1:0]   addr_nxt;

  assign rx_n     = {rx[RX_W-2:0], din_s};
  assign cmd_addr = rx_n[ADDR_W-1:0];
  assign addr_nxt = addr_wrap(addr, NUM_REGS);

  // Unified read view; addresses beyond NUM_REGS read as zero.
  for (genvar i = 0; i < MAP_N; i++) begin : g_map
    if (i < NUM_WR) begin : g_wr
      assign map[i] = wr_q[i];
    end else if (i < NUM_REGS) begin : g_rd
      assign map[i] = rd_regs[(i-NUM_WR)*DATA_W +: DATA_W];
    end else begin : g_zero
      assign map[i] = '0;
    end
  end

  for (genvar i = 0; i < NUM_WR; i++) begin : g_out
    assign wr_regs[i*DATA_W +: DATA_W] = wr_q[i];
  end

  always_ff @(posedge iclk) begin
    if (rst) begin
      state        <= IDLE;
      bit_cnt      <= '0;
      to_cnt       <= '0;
      rx           <= '0;
      tx           <= '0;
      addr         <= '0;
      rw           <= 1'b0;
      commit_en    <= 1'b0;
      commit_addr  <= '0;
      commit_data  <= '0;
      serial_out   <= 1'b0;
      wr_strobe    <= '0;
      frame_active <= 1'b0;
      addr_err     <= 1'b0;
      for (int i = 0; i < NUM_WR; i++)
        wr_q[i] <= WR_RST_VAL;
    end else begin
      wr_strobe <= '0;
      commit_en <= 1'b0;
      for (int i = 0; i < NUM_WR; i++) begin
        if (commit_en && int'(commit_addr) == i) begin
          wr_q[i]      <= commit_data;
          wr_strobe[i] <= 1'b1;
        end
      end

      unique case (state)
        IDLE: begin
          serial_out <= 1'b0;
          tx         <= '0;
          to_cnt     <= '0;
          bit_cnt    <= '0;
          if (sclk_rise) begin
            state        <= CMD;
            frame_active <= 1'b1;
            addr_err     <= 1'b0;
            rx           <= rx_n;
            bit_cnt      <= CNT_W'(1);
          end
        end

        CMD, DATA: begin
          if (sclk_rise || sclk_fall)
            to_cnt <= '0;
          else if (to_cnt != TO_MAX)
            to_cnt <= to_cnt + TO_W'(1);

          if (sclk_rise) begin
            rx      <= rx_n;
            bit_cnt <= bit_cnt + CNT_W'(1);
            if (state == CMD && bit_cnt == CMD_LAST) begin
              state   <= DATA;
              bit_cnt <= '0;
              rw      <= rx_n[RW_BIT];
              addr    <= cmd_addr;
              if (!rx_n[RW_BIT]) begin
                tx <= map[cmd_addr];
                if (int'(cmd_addr) >= NUM_REGS)
                  addr_err <= 1'b1;
              end
            end else if (state == DATA && bit_cnt == DATA_LAST) begin
              bit_cnt <= '0;
              addr    <= addr_nxt;
              if (rw) begin
                if (int'(addr) < NUM_WR) begin
                  commit_en   <= 1'b1;
                  commit_addr <= addr;
                  commit_data <= rx_n[DATA_W-1:0];
                end else if (int'(addr) >= NUM_REGS) begin
                  addr_err <= 1'b1;
                end
              end else begin
                tx <= map[addr_nxt];
                if (int'(addr_nxt) >= NUM_REGS)
                  addr_err <= 1'b1;
              end
            end
          end else if (sclk_fall) begin
            serial_out <= tx[DATA_W-1];
            tx         <= tx << 1;
          end else if (to_cnt == TO_MAX) begin
            // Idle bus: drop any partial word and release POCI.
            state        <= IDLE;
            frame_active <= 1'b0;
            serial_out   <= 1'b0;
            bit_cnt      <= '0;
          end
        end

        default: begin
          state        <= IDLE;
          frame_active <= 1'b0;
        end
      endcase
    end
  end

  logic unused_lvl;
  assign unused_lvl = sclk_lvl;

endmodule

// File: tb/tb_spi_regfile_target.sv
// Scoreboard bench: stimulus queues expected writes/reads,
// independent monitors pop them when the DUT strobes or shifts a word out.
module tb_spi_regfile_target;

  localparam int DW  = 8;
  localparam int NR  = 60;
  localparam int NW  = 4;
  localparam int TO  = 64;

  logic              iclk;
  logic              rst;
  logic              sclk;
  logic              serial_in;
  logic              serial_out;
  logic [(NR-NW)*DW-1:0] rd_regs;
  logic [NW*DW-1:0]  wr_regs;
  logic [NW-1:0]     wr_strobe;
  logic              frame_active;
  logic              addr_err;

  spi_regfile_target #(
    .DATA_W      (DW),
    .NUM_REGS    (NR),
    .NUM_WR      (NW),
    .TIMEOUT_CYC (TO),
    .WR_RST_VAL  ('0)
  ) dut (
    .iclk         (iclk),
    .rst          (rst),
    .sclk         (sclk),
    .serial_in    (serial_in),
    .serial_out   (serial_out),
    .rd_regs      (rd_regs),
    .wr_regs      (wr_regs),
    .wr_strobe    (wr_strobe),
    .frame_active (frame_active),
    .addr_err     (addr_err)
  );

  initial iclk = 1'b0;
  always #5 iclk = ~iclk;

  typedef struct {
    int       idx;
    logic [7:0] val;
  } wr_exp_t;

  wr_exp_t    wq[$];
  logic [7:0] rq[$];
  logic [7:0] mdl [NW];

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] exp_rd(input int a);
    if (a < NW) return mdl[a];
    if (a < NR) return rd_regs[(a-NW)*DW +: DW];
    return 8'h00;
  endfunction

  task automatic push_wr(input int idx, input logic [7:0] v);
    wr_exp_t e;
    e.idx = idx;
    e.val = v;
    wq.push_back(e);
    mdl[idx] = v;
  endtask

  task automatic send_bits(input logic [31:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      @(negedge iclk);
      serial_in = v[i];
      repeat (4) @(negedge iclk);
      sclk = 1'b1;
      repeat (5) @(negedge iclk);
      sclk = 1'b0;
    end
  endtask

  task automatic idle_gap();
    repeat (TO + 20) @(negedge iclk);
  endtask

  // Write monitor: each strobe must match the oldest queued write.
  logic [NW-1:0] prev_strobe = '0;
  initial begin
    forever begin
      @(negedge iclk);
      if (wr_strobe != '0) begin
        checks++;
        if (wq.size() == 0) begin
          failures++;
          $display("FAIL wr_unexpected strobe=%b required=none", wr_strobe);
        end else begin
          wr_exp_t e;
          e = wq.pop_front();
          if (wr_strobe != (NW'(1) << e.idx) ||
              wr_regs[e.idx*DW +: DW] != e.val) begin
            failures++;
            $display("FAIL wr_commit strobe=%b data=%h required strobe_bit=%0d data=%h",
                     wr_strobe, wr_regs[e.idx*DW +: DW], e.idx, e.val);
          end
        end
        if (prev_strobe != '0) begin
          failures++;
          $display("FAIL wr_strobe_width prev=%b now=%b required=0", prev_strobe, wr_strobe);
        end
      end
      prev_strobe = wr_strobe;
    end
  end

  // Read monitor: follows the bus and assembles POCI words in read frames.
  int         mcnt  = 0;
  logic       is_rd = 1'b0;
  logic [7:0] rsh   = '0;
  initial begin
    forever begin
      @(posedge sclk);
      if (!frame_active) mcnt = 0;
      mcnt++;
      if (mcnt == 1) begin
        is_rd = !serial_in;
      end else if (mcnt > 8 && is_rd) begin
        rsh = {rsh[6:0], serial_out};
        if ((mcnt - 8) % 8 == 0) begin
          checks++;
          if (rq.size() == 0) begin
            failures++;
            $display("FAIL rd_unexpected actual=%h required=none", rsh);
          end else begin
            logic [7:0] e;
            e = rq.pop_front();
            if (rsh !== e) begin
              failures++;
              $display("FAIL rd_word actual=%h required=%h", rsh, e);
            end
          end
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    sclk      = 1'b0;
    serial_in = 1'b0;
    for (int k = 0; k < NR - NW; k++)
      rd_regs[k*DW +: DW] = 8'(k) ^ 8'hA0;
    rd_regs[(10-NW)*DW +: DW] = 8'h5E;
    rd_regs[(11-NW)*DW +: DW] = 8'h33;
    rd_regs[(59-NW)*DW +: DW] = 8'hC7;
    for (int i = 0; i < NW; i++) mdl[i] = 8'h00;

    repeat (4) @(negedge iclk);
    chk("rst_wr_regs", 64'(wr_regs), 64'h0);
    chk("rst_strobe", 64'(wr_strobe), 64'h0);
    chk("rst_serial_out", 64'(serial_out), 64'h0);
    chk("rst_frame_active", 64'(frame_active), 64'h0);
    chk("rst_addr_err", 64'(addr_err), 64'h0);
    rst = 1'b0;
    repeat (4) @(negedge iclk);

    // Write burst into regs 0 and 1.
    push_wr(0, 8'hA5);
    push_wr(1, 8'h3C);
    send_bits(32'h80, 8);
    send_bits(32'hA5, 8);
    send_bits(32'h3C, 8);
    idle_gap();
    chk("t1_reg0", 64'(wr_regs[0*DW +: DW]), 64'hA5);
    chk("t1_reg1", 64'(wr_regs[1*DW +: DW]), 64'h3C);
    chk("t1_reg2", 64'(wr_regs[2*DW +: DW]), 64'h00);
    chk("t1_reg3", 64'(wr_regs[3*DW +: DW]), 64'h00);

    // Read burst from 10, 11.
    rq.push_back(8'h5E);
    rq.push_back(8'h33);
    send_bits(32'h0A, 8);
    send_bits(32'h0, 16);
    idle_gap();
    chk("t2_serial_out_idle", 64'(serial_out), 64'h0);

    // Wrap from last address to 0.
    rq.push_back(exp_rd(59));
    rq.push_back(exp_rd(0));
    send_bits(32'h3B, 8);
    send_bits(32'h0, 16);
    idle_gap();
    chk("t3_addr_err", 64'(addr_err), 64'h0);

    // Timeout with a partial word.
    send_bits(32'h81, 8);
    send_bits(32'h15, 5);
    chk("t4_active_mid", 64'(frame_active), 64'h1);
    idle_gap();
    chk("t4_active_after", 64'(frame_active), 64'h0);
    chk("t4_reg1_kept", 64'(wr_regs[1*DW +: DW]), 64'h3C);
    push_wr(1, 8'h77);
    send_bits(32'h81, 8);
    send_bits(32'h77, 8);
    idle_gap();
    chk("t4_reg1_new", 64'(wr_regs[1*DW +: DW]), 64'h77);

    // Out-of-range write and read.
    send_bits(32'hFF, 8);
    send_bits(32'h11, 8);
    idle_gap();
    chk("t5_err_wr", 64'(addr_err), 64'h1);
    chk("t5_regs", 64'(wr_regs), {32'h0, mdl[3], mdl[2], mdl[1], mdl[0]});
    rq.push_back(8'h00);
    send_bits(32'h70, 8);
    send_bits(32'h0, 8);
    idle_gap();
    chk("t5_err_rd", 64'(addr_err), 64'h1);
    push_wr(2, 8'h99);
    send_bits(32'h82, 8);
    chk("t5_err_cleared", 64'(addr_err), 64'h0);
    send_bits(32'h99, 8);
    idle_gap();
    chk("t5_reg2", 64'(wr_regs[2*DW +: DW]), 64'h99);

    // Reset in the middle of a write.
    send_bits(32'h83, 8);
    send_bits(32'hA, 4);
    @(negedge iclk);
    rst = 1'b1;
    @(negedge iclk);
    rst = 1'b0;
    for (int i = 0; i < NW; i++) mdl[i] = 8'h00;
    chk("t6_wr_regs", 64'(wr_regs), 64'h0);
    chk("t6_frame_active", 64'(frame_active), 64'h0);
    chk("t6_addr_err", 64'(addr_err), 64'h0);
    chk("t6_serial_out", 64'(serial_out), 64'h0);
    chk("t6_strobe", 64'(wr_strobe), 64'h0);
    repeat (10) @(negedge iclk);
    push_wr(3, 8'h5A);
    send_bits(32'h83, 8);
    send_bits(32'h5A, 8);
    idle_gap();
    chk("t6_reg3", 64'(wr_regs[3*DW +: DW]), 64'h5A);

    // Read back the whole writable window.
    for (int i = 0; i < NW; i++) rq.push_back(exp_rd(i));
    send_bits(32'h00, 8);
    send_bits(32'h0, 32);
    idle_gap();

    chk("wq_drained", 64'(wq.size()), 64'h0);
    chk("rq_drained", 64'(rq.size()), 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
